// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: RV32I funct3 codes, FSM states
// and the access legality check used on every accepted request.
package load_store_unit_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_RMW_WR = 1'b1
  } lsu_state_e;

  // Unsigned variants exist only for loads; reserved funct3 codes are always illegal.
  function automatic logic access_err(input logic we, input logic [2:0] f3,
                                      input logic [1:0] lo);
    logic e;
    e = 1'b0;
    case (f3)
      F3_LB:   e = 1'b0;
      F3_LBU:  e = we;
      F3_LH:   e = lo[0];
      F3_LHU:  e = we | lo[0];
      F3_LW:   e = (lo != 2'b00);
      default: e = 1'b1;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request/response channel plus word-memory bus of the load/store unit.
// slave = the LSU itself; master = execute stage and data memory side.
interface load_store_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic [ADDR_W-1:0] mem_A;
  logic [DATA_W-1:0] mem_WD;
  logic              mem_WE;
  logic [DATA_W-1:0] mem_RD;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_RD,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_A, mem_WD, mem_WE
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_RD,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_A, mem_WD, mem_WE
  );
endinterface

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: little-endian load extract/extend and sub-word
// store merge into an existing memory word.
module lsu_lane_align
  import load_store_unit_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] data,
  input  logic [1:0]  lo,
  input  logic [2:0]  funct3,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [31:0] shifted;

  assign shifted = word >> {lo, 3'b000};

  always_comb begin
    load_data = 32'd0;
    case (funct3)
      F3_LB:   load_data = {{24{shifted[7]}}, shifted[7:0]};
      F3_LBU:  load_data = {24'd0, shifted[7:0]};
      F3_LH:   load_data = {{16{shifted[15]}}, shifted[15:0]};
      F3_LHU:  load_data = {16'd0, shifted[15:0]};
      F3_LW:   load_data = word;
      default: load_data = 32'd0;
    endcase
  end

  always_comb begin
    store_word = word;
    case (funct3[1:0])
      2'b00:   store_word[{lo, 3'b000} +: 8]        = data[7:0];
      2'b01:   store_word[{lo[1], 4'b0000} +: 16]  = data[15:0];
      default: store_word = data;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store master for a word-addressed async-read memory. Loads and sw
// complete in 1 cycle; sb/sh take a 2-cycle read-modify-write with req_ready low.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic               clk,
  input logic               rst,
  load_store_unit_if.slave  bus
);

  lsu_state_e        state, state_nx;
  logic [ADDR_W-1:0] addr_q, cur_addr;
  logic [2:0]        f3_q, sel_f3;
  logic [DATA_W-1:0] wdata_q, old_word_q;
  logic [DATA_W-1:0] sel_word, sel_data, load_data, store_word;
  logic              xfer, err, we_int;
  logic              rsp_valid_q, rsp_err_q;
  logic [DATA_W-1:0] rsp_rdata_q;

  assign bus.req_ready = (state == ST_IDLE);
  assign xfer          = bus.req_valid & (state == ST_IDLE);
  assign err           = access_err(bus.req_we, bus.req_funct3, bus.req_addr[1:0]);

  // In RMW_WR the lane merge runs on the captured request, not the live bus.
  always_comb begin
    cur_addr = bus.req_addr;
    sel_word = bus.mem_RD;
    sel_data = bus.req_wdata;
    sel_f3   = bus.req_funct3;
    if (state == ST_RMW_WR) begin
      cur_addr = addr_q;
      sel_word = old_word_q;
      sel_data = wdata_q;
      sel_f3   = f3_q;
    end
  end

  lsu_lane_align u_align (
    .word       (sel_word),
    .data       (sel_data),
    .lo         (cur_addr[1:0]),
    .funct3     (sel_f3),
    .load_data  (load_data),
    .store_word (store_word)
  );

  assign bus.mem_A  = {cur_addr[ADDR_W-1:2], 2'b00};
  assign bus.mem_WD = store_word;
  assign bus.mem_WE = we_int & ~rst;

  always_comb begin
    state_nx = state;
    we_int   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (xfer && !err && bus.req_we) begin
          if (bus.req_funct3 == F3_LW) we_int   = 1'b1;
          else                         state_nx = ST_RMW_WR;
        end
      end
      ST_RMW_WR: begin
        we_int   = 1'b1;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state       <= state_nx;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      if (state == ST_RMW_WR) begin
        rsp_valid_q <= 1'b1;
        rsp_rdata_q <= '0;
      end else if (xfer) begin
        if (err) begin
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= 1'b1;
          rsp_rdata_q <= '0;
        end else if (!bus.req_we) begin
          rsp_valid_q <= 1'b1;
          rsp_rdata_q <= load_data;
        end else if (bus.req_funct3 == F3_LW) begin
          rsp_valid_q <= 1'b1;
          rsp_rdata_q <= '0;
        end
      end
    end
  end

  // Sub-word store operands; the old word is the memory read in the accept cycle.
  always_ff @(posedge clk) begin
    if (xfer && !err && bus.req_we && bus.req_funct3 != F3_LW) begin
      addr_q     <= bus.req_addr;
      f3_q       <= bus.req_funct3;
      wdata_q    <= bus.req_wdata;
      old_word_q <= bus.mem_RD;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-array reference model, directed cases and a random mix.
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   nvec = 0;
  int   nerr = 0;
  int   n_acc = 0;

  logic [31:0] mem   [0:255];
  logic [7:0]  ref_b [0:1023];
  exp_t        exp_q [$];
  bit          rmw_pend = 1'b0;
  logic [2:0]  pend_f3;
  logic [31:0] pend_addr, pend_wd;

  load_store_unit_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  assign bus.mem_RD = mem[bus.mem_A[9:2]];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int acc_size(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      2'b10:   return 4;
      default: return 0;
    endcase
  endfunction

  function automatic bit ref_legal(input bit we, input logic [2:0] f3, input logic [31:0] a);
    int n;
    n = acc_size(f3);
    if (n == 0 || f3 == 3'b110 || f3 == 3'b111) return 1'b0;
    if (we && f3[2]) return 1'b0;
    return (a % n) == 0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
    int n;
    logic [31:0] v, mask;
    n = acc_size(f3);
    v = 32'd0;
    for (int i = 0; i < n; i++) v = v | (32'(ref_b[(a + i) % 1024]) << (8 * i));
    if (n < 4) begin
      mask = (32'd1 << (8 * n)) - 32'd1;
      if (!f3[2] && v[8*n-1]) v = v | ~mask;
    end
    return v;
  endfunction

  task automatic ref_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    int n;
    logic [31:0] t;
    n = acc_size(f3);
    for (int i = 0; i < n; i++) begin
      t = wd >> (8 * i);
      ref_b[(a + i) % 1024] = t[7:0];
    end
  endtask

  task automatic preload(input int widx, input logic [31:0] v);
    mem[widx] = v;
    for (int i = 0; i < 4; i++) ref_b[4*widx + i] = v[8*i +: 8];
  endtask

  // One clock of stimulus: check responses due now, drive, check write enable, advance model.
  task automatic step(input bit v, input bit we, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] wd, input bit r);
    bit          acc, exp_we, wr;
    logic [7:0]  idx;
    logic [31:0] wdat;
    @(negedge clk);
    if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
      chk("rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
      chk("rsp_rdata", bus.rsp_rdata, exp_q[0].rdata);
      chk("rsp_err", {31'd0, bus.rsp_err}, {31'd0, exp_q[0].err});
      void'(exp_q.pop_front());
    end else begin
      chk("rsp_valid_quiet", {31'd0, bus.rsp_valid}, 32'd0);
    end
    chk("req_ready", {31'd0, bus.req_ready}, {31'd0, !rmw_pend});
    rst            = r;
    bus.req_valid  = v;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    #1;
    acc    = v && !rmw_pend && !r;
    exp_we = !r && (rmw_pend || (acc && we && f3 == F3_LW && ref_legal(we, f3, a)));
    chk("mem_WE", {31'd0, bus.mem_WE}, {31'd0, exp_we});
    if (r) begin
      rmw_pend = 1'b0;
      exp_q.delete();
    end else if (rmw_pend) begin
      ref_store(pend_f3, pend_addr, pend_wd);
      rmw_pend = 1'b0;
      exp_q.push_back('{32'd0, 1'b0, cyc + 1});
    end else if (acc) begin
      n_acc++;
      if (!ref_legal(we, f3, a)) exp_q.push_back('{32'd0, 1'b1, cyc + 1});
      else if (!we) exp_q.push_back('{ref_load(f3, a), 1'b0, cyc + 1});
      else if (f3 == F3_LW) begin
        ref_store(f3, a, wd);
        exp_q.push_back('{32'd0, 1'b0, cyc + 1});
      end else begin
        pend_f3   = f3;
        pend_addr = a;
        pend_wd   = wd;
        rmw_pend  = 1'b1;
      end
    end
    wr   = bus.mem_WE;
    idx  = bus.mem_A[9:2];
    wdat = bus.mem_WD;
    if (wr) begin
      @(posedge clk);
      mem[idx] = wdat;
    end
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 1'b0);
  endtask

  initial begin
    logic [2:0]  f3;
    logic [31:0] a;
    int          n, tgt;
    logic [2:0]  legal_f3 [5];
    legal_f3 = '{F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
    for (int w = 0; w < 256; w++) preload(w, $urandom);
    preload(32'h40 / 4, 32'h8899AABB);
    preload(32'h20 / 4, 32'h11223344);
    preload(32'h30 / 4, 32'hCAFEF00D);
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'b000;
    bus.req_addr = 32'd0; bus.req_wdata = 32'd0;
    repeat (2) @(posedge clk);

    // Reset state
    idle();
    chk("rst_rdata", bus.rsp_rdata, 32'd0);
    chk("rst_err", {31'd0, bus.rsp_err}, 32'd0);

    // Lane extraction on 0x8899AABB, back to back
    step(1'b1, 1'b0, F3_LB,  32'h41, 32'd0, 1'b0);
    step(1'b1, 1'b0, F3_LBU, 32'h41, 32'd0, 1'b0);
    chk("lb_41", bus.rsp_rdata, 32'hFFFFFFAA);
    step(1'b1, 1'b0, F3_LHU, 32'h42, 32'd0, 1'b0);
    chk("lbu_41", bus.rsp_rdata, 32'h000000AA);
    idle();
    chk("lhu_42", bus.rsp_rdata, 32'h00008899);

    // sw then lw of the same word, no stall
    step(1'b1, 1'b1, F3_LW, 32'h10, 32'h12345678, 1'b0);
    step(1'b1, 1'b0, F3_LW, 32'h10, 32'd0, 1'b0);
    idle();
    chk("sw_lw_10", bus.rsp_rdata, 32'h12345678);

    // sb read-modify-write
    step(1'b1, 1'b1, F3_LB, 32'h22, 32'h000000EE, 1'b0);
    step(1'b1, 1'b0, F3_LW, 32'h20, 32'd0, 1'b0);
    idle();
    idle();
    chk("sb_22_mem", mem[32'h20 / 4], 32'h11EE3344);

    // Misaligned and illegal requests
    step(1'b1, 1'b0, F3_LW, 32'h06, 32'd0, 1'b0);
    step(1'b1, 1'b1, F3_LH, 32'h03, 32'hFFFF, 1'b0);
    chk("lw_06_err", {31'd0, bus.rsp_err}, 32'd1);
    step(1'b1, 1'b0, 3'b011, 32'h00, 32'd0, 1'b0);
    chk("sh_03_err", {31'd0, bus.rsp_err}, 32'd1);
    idle();
    chk("f3_011_err", {31'd0, bus.rsp_err}, 32'd1);
    chk("f3_011_rdata", bus.rsp_rdata, 32'd0);

    // Reset while in RMW_WR drops the write and the response
    step(1'b1, 1'b1, F3_LH, 32'h30, 32'h0000BEEF, 1'b0);
    step(1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 1'b1);
    idle();
    chk("rst_rmw_ready", {31'd0, bus.req_ready}, 32'd1);
    idle();
    chk("rst_rmw_mem", mem[32'h30 / 4], 32'hCAFEF00D);

    // Random mix
    tgt = n_acc + 1000;
    for (int it = 0; it < 8000 && n_acc < tgt; it++) begin
      f3 = ($urandom_range(0, 9) < 8) ? legal_f3[$urandom_range(0, 4)] : 3'($urandom_range(0, 7));
      a  = $urandom_range(0, 1023);
      n  = acc_size(f3);
      if (n != 0 && $urandom_range(0, 9) < 8) a = a - (a % n);
      step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, f3, a, $urandom, 1'b0);
    end
    chk("rand_count", {31'd0, n_acc >= tgt}, 32'd1);

    repeat (3) idle();
    chk("drain", exp_q.size(), 32'd0);
    for (int w = 0; w < 256; w++)
      chk($sformatf("mem_img[%0d]", w), mem[w],
          {ref_b[4*w+3], ref_b[4*w+2], ref_b[4*w+1], ref_b[4*w]});

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
